xf_load_sequencer: RTL



---
 rtl/xf_load_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/xf_load_sequencer.sv
// Turns CP "load XF" commands into single-word XF register writes at incrementing addresses.
// Bursts that would leave their 4 KiB XF region are drained from the FIFO and flagged with err.
module xf_load_sequencer #(
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [15:0]       cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic              abort,
  input  logic              xf_busy,
  output logic [15:0]       CPAddr,
  output logic              CPWrite,
  output logic [DATA_W-1:0] CPWriteData,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {StIdle, StLoad, StDiscard} state_e;

  state_e              r_state, w_state_d;
  logic [15:0]         r_cur_addr, w_cur_addr_d;
  logic [LEN_W-1:0]    r_remaining, w_remaining_d;
  logic [15:0]         r_cpaddr;
  logic                r_cpwrite;
  logic [DATA_W-1:0]   r_cpdata;
  logic                r_done, r_err;
  logic [16:0]         w_end;
  logic                w_region_bad;
  logic                w_cmd_fire, w_data_fire;
  logic                w_write, w_done_d, w_err_d;

  // 17-bit end address so a wrap past 0xFFFF is caught as well as a region change.
  assign w_end        = {1'b0, cmd_addr} + 17'(cmd_len);
  assign w_region_bad = w_end[16] | (w_end[15:12] != cmd_addr[15:12]);

  always_comb begin
    cmd_ready  = 1'b0;
    data_ready = 1'b0;
    unique case (r_state)
      StIdle:    cmd_ready  = 1'b1;
      StLoad:    data_ready = ~xf_busy & ~abort;
      StDiscard: data_ready = ~abort;
      default:   cmd_ready  = 1'b0;
    endcase
  end

  assign w_cmd_fire  = cmd_valid & cmd_ready;
  assign w_data_fire = data_valid & data_ready;

  always_comb begin
    w_state_d     = r_state;
    w_cur_addr_d  = r_cur_addr;
    w_remaining_d = r_remaining;
    w_write       = 1'b0;
    w_done_d      = 1'b0;
    w_err_d       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_cmd_fire) begin
          w_cur_addr_d  = cmd_addr;
          w_remaining_d = cmd_len;
          w_state_d     = w_region_bad ? StDiscard : StLoad;
        end
      end
      StLoad: begin
        if (abort) begin
          w_state_d = StIdle;
        end else if (w_data_fire) begin
          w_write       = 1'b1;
          w_cur_addr_d  = r_cur_addr + 16'd1;
          w_remaining_d = r_remaining - 1'b1;
          if (r_remaining == '0) begin
            w_done_d  = 1'b1;
            w_state_d = StIdle;
          end
        end
      end
      StDiscard: begin
        if (abort) begin
          w_state_d = StIdle;
        end else if (w_data_fire) begin
          w_remaining_d = r_remaining - 1'b1;
          if (r_remaining == '0) begin
            w_err_d   = 1'b1;
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= StIdle;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_cpaddr    <= '0;
      r_cpwrite   <= 1'b0;
      r_cpdata    <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cur_addr  <= w_cur_addr_d;
      r_remaining <= w_remaining_d;
      r_cpwrite   <= w_write;
      r_done      <= w_done_d;
      r_err       <= w_err_d;
      // Address and data hold their last values between writes.
      if (w_write) begin
        r_cpaddr <= r_cur_addr;
        r_cpdata <= data_in;
      end
    end
  end

  assign CPAddr      = r_cpaddr;
  assign CPWrite     = r_cpwrite;
  assign CPWriteData = r_cpdata;
  assign done        = r_done;
  assign err         = r_err;
  assign busy        = (r_state != StIdle);

endmodule
